mem_port_arbiter: RTL

- Sits directly downstream of the pipelined LC-3b core's two memory ports: IF (instruction fetch, read-only) and MEM (data read/write).
- Merges both ports onto one physical memory port, one transaction at a time, so a single-ported memory/cache can back the core.
- MEM normally has priority; a starvation counter guarantees IF forward progress.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the LC-3b core's IF/MEM ports, the arbiter and the single physical memory port.
// The slave modport is the arbiter's view. The master modport is the surrounding core plus memory.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] if_memaddr;
    logic                  if_memread;
    logic [1:0]            if_mem_byte_enable;
    logic                  if_mem_resp;
    logic [DATA_WIDTH-1:0] if_mem_rdata;

    logic [ADDR_WIDTH-1:0] mem_memaddr;
    logic                  mem_memread;
    logic                  mem_memwrite;
    logic [DATA_WIDTH-1:0] mem_mem_wdata;
    logic [1:0]            mem_mem_byte_enable;
    logic                  mem_mem_resp;
    logic [DATA_WIDTH-1:0] mem_mem_rdata;

    logic [ADDR_WIDTH-1:0] pmem_address;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [DATA_WIDTH-1:0] pmem_wdata;
    logic [1:0]            pmem_byte_enable;
    logic                  pmem_resp;
    logic [DATA_WIDTH-1:0] pmem_rdata;

    modport slave (
        input  if_memaddr, if_memread, if_mem_byte_enable,
        input  mem_memaddr, mem_memread, mem_memwrite, mem_mem_wdata, mem_mem_byte_enable,
        input  pmem_resp, pmem_rdata,
        output if_mem_resp, if_mem_rdata, mem_mem_resp, mem_mem_rdata,
        output pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable
    );

    modport master (
        output if_memaddr, if_memread, if_mem_byte_enable,
        output mem_memaddr, mem_memread, mem_memwrite, mem_mem_wdata, mem_mem_byte_enable,
        output pmem_resp, pmem_rdata,
        input  if_mem_resp, if_mem_rdata, mem_mem_resp, mem_mem_rdata,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges the LC-3b IF and MEM ports onto one physical memory port, one transaction at a time.
// MEM has priority, and a saturating starvation counter forces an IF grant after STARVE_LIMIT MEM grants.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE_IF  = 2'd1,
        ST_SERVE_MEM = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_starve_cnt;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [DATA_WIDTH-1:0] r_pmem_wdata;
    logic [1:0]            r_pmem_byte_enable;

    logic w_mem_req;
    logic w_if_req;
    logic w_starved;
    logic w_if_wins;

    assign w_mem_req = bus.mem_memread | bus.mem_memwrite;
    assign w_if_req  = bus.if_memread;
    assign w_starved = (r_starve_cnt >= 4'(STARVE_LIMIT));
    assign w_if_wins = w_if_req & (~w_mem_req | w_starved);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_starve_cnt       <= '0;
            r_pmem_address     <= '0;
            r_pmem_read        <= 1'b0;
            r_pmem_write       <= 1'b0;
            r_pmem_wdata       <= '0;
            r_pmem_byte_enable <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_if_wins) begin
                        r_state            <= ST_SERVE_IF;
                        r_starve_cnt       <= '0;
                        r_pmem_address     <= bus.if_memaddr;
                        r_pmem_byte_enable <= bus.if_mem_byte_enable;
                        r_pmem_read        <= 1'b1;
                        r_pmem_write       <= 1'b0;
                    end else if (w_mem_req) begin
                        r_state            <= ST_SERVE_MEM;
                        r_pmem_address     <= bus.mem_memaddr;
                        r_pmem_byte_enable <= bus.mem_mem_byte_enable;
                        r_pmem_wdata       <= bus.mem_mem_wdata;
                        // read+write together is illegal and resolves to a write
                        r_pmem_write       <= bus.mem_memwrite;
                        r_pmem_read        <= ~bus.mem_memwrite;
                        if (!w_if_req)
                            r_starve_cnt <= '0;
                        else if (r_starve_cnt != 4'hF)
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                ST_SERVE_IF, ST_SERVE_MEM: begin
                    if (bus.pmem_resp) begin
                        r_state      <= ST_IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pmem_address     = r_pmem_address;
    assign bus.pmem_read        = r_pmem_read;
    assign bus.pmem_write       = r_pmem_write;
    assign bus.pmem_wdata       = r_pmem_wdata;
    assign bus.pmem_byte_enable = r_pmem_byte_enable;

    assign bus.if_mem_resp   = (r_state == ST_SERVE_IF)  & bus.pmem_resp;
    assign bus.mem_mem_resp  = (r_state == ST_SERVE_MEM) & bus.pmem_resp;
    assign bus.if_mem_rdata  = bus.pmem_rdata;
    assign bus.mem_mem_rdata = bus.pmem_rdata;
endmodule
